alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Issues ALU operations requested by the pipeline over a valid/ready handshake and returns one result
//  per request. Single-cycle ops are issued for one cycle. Multiply (func 5) is held until mult_fin.
//  After a multiply it drains the multiplier (drives IDLE_FUNC until mult_fin clears). Flags illegal
//  funcs and multiply timeouts. Sits between decode/execute control and the alu instance.
// PARAMETERS
//  MUL_TIMEOUT  40     max MUL-state cycles before abort; timeout counter is $clog2(MUL_TIMEOUT+1) bits
//  IDLE_FUNC    4'd0   func driven to the alu whenever no op is issued (must not be 5)
//  CNT_W        16     width of ops_done counter
// PORTS
//  clk            in   1      clock, rising edge
//  rst            in   1      synchronous reset, active high
//  req_valid      in   1      request present
//  req_ready      out  1      sequencer can accept (high only in IDLE)
//  req_func       in   4      ALU func code
//  req_a, req_b   in   32     operands
//  rsp_valid      out  1      result present
//  rsp_ready      in   1      consumer takes result
//  rsp_data       out  32     result
//  rsp_err        out  1      1 = illegal func or multiply timeout (rsp_data = 0)
//  alu_func       out  4      to alu func
//  alu_a, alu_b   out  32     to alu operands
//  alu_out        in   32     from alu out
//  alu_mult_fin   in   1      from alu mult_fin
//  busy           out  1      state != IDLE
//  ops_done       out  CNT_W  responses completed, wraps at 2^CNT_W
// BEHAVIOUR
//  Reset: state IDLE. req_ready=1; rsp_valid=0, rsp_err=0, rsp_data=0, alu_func=IDLE_FUNC,
//   alu_a=alu_b=0, busy=0, ops_done=0, timeout counter=0. rst mid-op aborts with no response.
//   The next cycle drives IDLE_FUNC, which releases/resets the multiplier.
//  Legal funcs: 0,2,11,13,14,15 (single-cycle), 5 (multiply). All others are illegal.
//  Accept = req_valid & req_ready at an edge; func/a/b are registered at that edge.
//  States:
//   IDLE  : alu_func=IDLE_FUNC, alu_a/b=0. On accept: illegal -> RESP (err=1, data=0);
//           func 5 -> MUL (counter=0); else -> EXEC.
//   EXEC  : drive registered func/a/b for exactly 1 cycle. At the edge, capture alu_out -> RESP, err=0.
//   MUL   : drive func=5 and the registered operands. Counter +1 per cycle.
//           At each edge: if alu_mult_fin=1, capture alu_out, err=0 -> DRAIN.
//           Else if counter==MUL_TIMEOUT-1: data=0, err=1 -> DRAIN.
//           fin wins if it coincides with timeout.
//   DRAIN : alu_func=IDLE_FUNC, operands 0. Go to RESP at the first edge that samples alu_mult_fin=0.
//           The minimum stay is 1 cycle, so a stale fin cannot end the next multiply.
//   RESP  : rsp_valid=1. rsp_data/rsp_err stay stable until rsp_ready; alu_func=IDLE_FUNC.
//           On rsp_ready: ops_done+1 (wrap) -> IDLE.
//  Latency (accept at edge k):
//   single-cycle op and illegal func: rsp_valid from edge k+2 and k+1 respectively.
//   multiply with fin sampled at edge m: rsp_valid from edge m+2 minimum.
//  Only one op is in flight; req_ready=0 in every state except IDLE, including RESP.
//  rsp_valid never drops without rsp_ready. Outputs are registered/state-decoded; no comb path req->rsp.
//  alu_func is never 5 outside MUL.
//  rsp_data holds the low 32 bits only (alu truncates the product); no overflow flag.
// TESTING
//  1 add: func0 a=5 b=7 accepted at edge k -> rsp_valid at k+2, rsp_data=12, err=0, ops_done=1.
//  2 mul: func5 a=6 b=7, real alu/multiplier -> alu_func=5 until fin, then IDLE_FUNC;
//    rsp_data=42; req_ready=0 throughout; a second mul 3*0xFFFFFFFF -> 0xFFFFFFFD.
//  3 illegal: func 4'd3 -> rsp at k+1, err=1, data=0; alu_func stays IDLE_FUNC.
//  4 timeout: stub mult_fin tied 0 -> rsp after 40 MUL cycles with err=1, data=0;
//    fin pulsed on cycle 40 -> err=0.
//  5 backpressure: func13 a=0xF0 b=0x0F, rsp_ready low 5 cycles -> data 0xFF stable, req_valid held
//    but not accepted; accepted on the cycle after the rsp_ready handshake.
//  6 reset: assert rst in MUL cycle 10 -> next cycle in reset state, no rsp; then mul 9*9 -> 81.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: valid/ready front end issuing single-cycle and multiply ops to an alu
module alu_op_sequencer #(
    parameter int         MUL_TIMEOUT = 40,
    parameter logic [3:0] IDLE_FUNC   = 4'd0,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_func,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_err,
    output logic [3:0]       alu_func,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    input  logic [31:0]      alu_out,
    input  logic             alu_mult_fin,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);
    localparam int         TW       = $clog2(MUL_TIMEOUT + 1);
    localparam logic [3:0] MUL_FUNC = 4'd5;
    typedef enum logic [2:0] {IDLE, EXEC, MUL, DRAIN, RESP} state_t;
    state_t        state;
    logic [TW-1:0] cnt;
    logic          legal;
    always_comb legal = req_func inside {4'd0, 4'd2, 4'd11, 4'd13, 4'd14, 4'd15, MUL_FUNC};
    // alu_a/alu_b double as the registered request operands while an op is issued
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            alu_func  <= IDLE_FUNC;
            alu_a     <= '0;
            alu_b     <= '0;
            ops_done  <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    req_ready <= 1'b0;
                    busy      <= 1'b1;
                    if (!legal) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                    end else begin
                        state    <= (req_func == MUL_FUNC) ? MUL : EXEC;
                        cnt      <= '0;
                        alu_func <= req_func;
                        alu_a    <= req_a;
                        alu_b    <= req_b;
                    end
                end
                EXEC: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= alu_out;
                    rsp_err   <= 1'b0;
                    alu_func  <= IDLE_FUNC;
                    alu_a     <= '0;
                    alu_b     <= '0;
                end
                MUL: begin
                    cnt <= cnt + 1'b1;
                    if (alu_mult_fin || cnt == TW'(MUL_TIMEOUT - 1)) begin
                        state    <= DRAIN;
                        rsp_data <= alu_mult_fin ? alu_out : '0;
                        rsp_err  <= !alu_mult_fin;
                        alu_func <= IDLE_FUNC;
                        alu_a    <= '0;
                        alu_b    <= '0;
                    end
                end
                DRAIN: if (!alu_mult_fin) begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                end
                RESP: if (rsp_ready) begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    ops_done  <= ops_done + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and random ops against a behavioural alu/multiplier and response model
module tb_alu_op_sequencer;
    logic        clk = 0, rst = 1;
    logic        req_valid = 0, req_ready, rsp_valid, rsp_ready = 0, rsp_err, busy, fin = 0;
    logic [3:0]  req_func = 0, alu_func;
    logic [31:0] req_a = 0, req_b = 0, rsp_data, alu_a, alu_b, alu_out, prod = 0;
    logic [15:0] ops_done;
    int          checks = 0, failures = 0, mcnt = 0, dcnt = 0, mul_lat = 1, drain_lat = 0, m_ops = 0;
    bit          inflight = 0;
    logic [31:0] exp_data = 0;
    logic        exp_err = 0;

    alu_op_sequencer dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .alu_func(alu_func), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_mult_fin(fin), .busy(busy), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            4'd0:  return a + b;
            4'd2:  return a - b;
            4'd11: return a & b;
            4'd13: return a | b;
            4'd14: return a ^ b;
            4'd15: return a << b[4:0];
            default: return 32'hBAD0BAD0;
        endcase
    endfunction

    // alu stub: product shows only once fin is up, so an early capture is visible
    always_comb alu_out = (alu_func == 4'd5) ? (fin ? prod : 32'hDEADBEEF) : op(alu_func, alu_a, alu_b);

    // multiplier: fin rises mul_lat cycles into func 5, falls drain_lat+1 cycles after func leaves 5
    always @(posedge clk) begin
        if (rst) begin
            fin <= 0; mcnt <= 0; dcnt <= 0;
        end else if (alu_func == 4'd5) begin
            mcnt <= mcnt + 1;
            dcnt <= 0;
            if (mcnt == mul_lat - 1) begin
                fin  <= 1;
                prod <= alu_a * alu_b;
            end
        end else begin
            mcnt <= 0;
            if (fin) begin
                if (dcnt >= drain_lat) begin fin <= 0; dcnt <= 0; end
                else dcnt <= dcnt + 1;
            end
        end
    end

    function automatic bit is_legal(input logic [3:0] f);
        return f inside {4'd0, 4'd2, 4'd5, 4'd11, 4'd13, 4'd14, 4'd15};
    endfunction

    // expected {err, data}: multiply times out when fin is first sampled after MUL cycle 40
    function automatic logic [32:0] ref_rsp(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b, input int l);
        if (!is_legal(f)) return {1'b1, 32'd0};
        if (f == 4'd5) return (l >= 40) ? {1'b1, 32'd0} : {1'b0, a * b};
        return {1'b0, op(f, a, b)};
    endfunction

    // edges from accept to the first edge sampling rsp_valid, given this bench's multiplier timing
    function automatic int exp_lat(input logic [3:0] f, input int l, input int dl);
        if (!is_legal(f)) return 1;
        if (f != 4'd5) return 2;
        if (l <= 39) return l + dl + 4;
        if (l == 40) return 40 + dl + 3;
        return 42;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) if (!rst) begin
        chk("ready", {31'd0, req_ready}, {31'd0, !inflight});
        chk("busy", {31'd0, busy}, {31'd0, inflight});
        chk("ops_done", {16'd0, ops_done}, 32'(m_ops));
        if (!inflight) begin
            chk("idle_valid", {31'd0, rsp_valid}, 0);
            chk("idle_func", {28'd0, alu_func}, 0);
            chk("idle_ops", alu_a | alu_b, 0);
        end
        if (rsp_valid) begin
            chk("rsp_data", rsp_data, exp_data);
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
        end
        if (alu_func == 4'd5) chk("func5_scope", {31'd0, inflight && !rsp_valid}, 1);
    end

    task automatic run_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int l, input int dl, input int bp, input bit keep,
                          output int lat, output logic [31:0] d, output logic e);
        logic [32:0] r;
        mul_lat = l; drain_lat = dl;
        req_func = f; req_a = a; req_b = b; req_valid = 1;
        @(posedge clk); #1;
        inflight = 1;
        r = ref_rsp(f, a, b, l);
        exp_err = r[32]; exp_data = r[31:0];
        req_valid = 0;
        if (!is_legal(f)) chk("acc_func", {28'd0, alu_func}, 0);
        else if (f != 4'd0) begin
            chk("acc_func", {28'd0, alu_func}, {28'd0, f});
            chk("acc_a", alu_a, a);
        end
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        d = rsp_data; e = rsp_err;
        if (keep) begin req_valid = 1; req_func = 4'd0; req_a = 1; req_b = 1; end
        repeat (bp) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, rsp_valid}, 1);
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0; inflight = 0; m_ops++;
    endtask

    initial begin
        int lat;
        logic [31:0] d;
        logic e;
        logic [3:0] fl [12] = '{4'd0, 4'd2, 4'd11, 4'd13, 4'd14, 4'd15, 4'd5, 4'd5, 4'd3, 4'd1, 4'd4, 4'd12};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, req_ready}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_valid", {31'd0, rsp_valid}, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_func", {28'd0, alu_func}, 0);
        chk("rst_ops", {16'd0, ops_done}, 0);
        rst = 0;
        run_op(4'd0, 5, 7, 1, 0, 0, 0, lat, d, e);
        chk("add_lat", lat, 2); chk("add_data", d, 12); chk("add_err", {31'd0, e}, 0);
        chk("add_ops", {16'd0, ops_done}, 1);
        run_op(4'd5, 6, 7, 3, 0, 0, 0, lat, d, e);
        chk("mul_data", d, 42); chk("mul_lat", lat, 7);
        run_op(4'd5, 3, 32'hFFFFFFFF, 5, 2, 1, 0, lat, d, e);
        chk("mul2_data", d, 32'hFFFFFFFD); chk("mul2_lat", lat, 11);
        run_op(4'd3, 1, 2, 1, 0, 0, 0, lat, d, e);
        chk("ill_lat", lat, 1); chk("ill_err", {31'd0, e}, 1); chk("ill_data", d, 0);
        run_op(4'd5, 2, 3, 1000, 0, 0, 0, lat, d, e);
        chk("to_lat", lat, 42); chk("to_err", {31'd0, e}, 1); chk("to_data", d, 0);
        run_op(4'd5, 2, 3, 39, 0, 0, 0, lat, d, e);
        chk("fin40_err", {31'd0, e}, 0); chk("fin40_data", d, 6); chk("fin40_lat", lat, 43);
        run_op(4'd5, 2, 3, 40, 0, 0, 0, lat, d, e);
        chk("fin41_err", {31'd0, e}, 1); chk("fin41_lat", lat, 43);
        run_op(4'd13, 32'hF0, 32'h0F, 1, 0, 5, 1, lat, d, e);
        chk("bp_data", d, 32'hFF);
        run_op(4'd0, 1, 1, 1, 0, 0, 0, lat, d, e);
        chk("bp_next_lat", lat, 2); chk("bp_next_data", d, 2);
        // reset during MUL cycle 10
        mul_lat = 30; req_func = 4'd5; req_a = 6; req_b = 6; req_valid = 1;
        @(posedge clk); #1;
        inflight = 1; exp_data = 36; exp_err = 0; req_valid = 0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0; inflight = 0; m_ops = 0;
        chk("mrst_busy", {31'd0, busy}, 0); chk("mrst_valid", {31'd0, rsp_valid}, 0);
        chk("mrst_func", {28'd0, alu_func}, 0); chk("mrst_ops", {16'd0, ops_done}, 0);
        run_op(4'd5, 9, 9, 4, 0, 0, 0, lat, d, e);
        chk("mrst_mul", d, 81);
        for (int i = 0; i < 60; i++) begin
            logic [3:0] f;
            logic [31:0] a, b;
            int l, dl;
            f = fl[$urandom_range(0, 11)];
            a = $urandom; b = $urandom;
            l = $urandom_range(1, 45); dl = $urandom_range(0, 3);
            run_op(f, a, b, l, dl, $urandom_range(0, 3), 0, lat, d, e);
            chk("rnd_lat", lat, exp_lat(f, l, dl));
            chk("rnd_rsp", {e, d}, ref_rsp(f, a, b, l));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
